// File: rtl/grad_pkg.sv
// grad_pkg: shared definitions for the gradient-magnitude pipeline.
//   grad_mode_t : per-pixel combine mode (L1, MAX, L2-approx, reserved)
//   GRAD_IN_W   : default width of the signed gx/gy gradients
//   GRAD_OUT_W  : default width of the saturated magnitude
//   GRAD_CNT_W  : default width of the edge counter
package grad_pkg;

   localparam int GRAD_IN_W  = 11;
   localparam int GRAD_OUT_W = 8;
   localparam int GRAD_CNT_W = 16;

   typedef enum logic [1:0] {
      GM_L1   = 2'b00,
      GM_MAX  = 2'b01,
      GM_L2A  = 2'b10,
      GM_RSVD = 2'b11   // behaves as L1
   } grad_mode_t;

endpackage

// File: rtl/grad_pipe_reg.sv
// grad_pipe_reg: one valid/ready register slice of width W.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : upstream handshake (in_ready = load condition)
//   in_data             : payload captured on acceptance
//   out_valid/out_ready : downstream handshake
//   out_data            : registered payload, stable while stalled
module grad_pipe_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         valid_reg;
   logic [W-1:0] data_reg;
   logic         load;

   // The slice refills when it is empty or its contents leave this cycle.
   assign load     = !valid_reg || out_ready;
   assign in_ready = load;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_reg <= 1'b0;
         data_reg  <= '0;
      end else if (load) begin
         valid_reg <= in_valid;
         if (in_valid)
            data_reg <= in_data;
      end
   end

   assign out_valid = valid_reg;
   assign out_data  = data_reg;

endmodule

// File: rtl/grad_mag_pipe.sv
// grad_mag_pipe: three-stage gradient-magnitude pipeline with edge detect.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : input handshake
//   gx, gy               : signed gradients (IN_W bits)
//   in_en                : per-pixel enable, 0 forces g = 0 and no edge
//   mode                 : combine mode (grad_mode_t encoding)
//   threshold            : edge threshold, sampled when entering stage 3
//   cnt_clear            : synchronous clear of edge_count
//   out_valid / out_ready: output handshake
//   g                    : saturated magnitude (OUT_W bits)
//   is_edge              : g >= threshold for enabled pixels
//   edge_count           : saturating count of transferred edge results
// Stage 1 stores |gx|,|gy|, stage 2 the IN_W+1 bit combined value,
// stage 3 the saturated magnitude and the edge flag.
module grad_mag_pipe
   import grad_pkg::*;
#(
   parameter int IN_W  = GRAD_IN_W,
   parameter int OUT_W = GRAD_OUT_W,
   parameter int CNT_W = GRAD_CNT_W
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic signed [IN_W-1:0] gx,
   input  logic signed [IN_W-1:0] gy,
   input  logic                   in_en,
   input  logic [1:0]             mode,
   input  logic [OUT_W-1:0]       threshold,
   input  logic                   cnt_clear,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [OUT_W-1:0]       g,
   output logic                   is_edge,
   output logic [CNT_W-1:0]       edge_count
);

   localparam int S1_W = 2 * IN_W + 3;
   localparam int S2_W = IN_W + 2;
   localparam int S3_W = OUT_W + 1;

   // ---------------- stage 1: absolute values ----------------
   logic signed [IN_W-1:0] raw [2];
   logic        [IN_W-1:0] mag [2];

   assign raw[0] = gx;
   assign raw[1] = gy;

   // An IN_W-bit unsigned result holds 2^(IN_W-1), so negating the most
   // negative input is exact once reinterpreted as unsigned.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_abs
         assign mag[gi] = raw[gi][IN_W-1] ? $unsigned(-raw[gi]) : $unsigned(raw[gi]);
      end
   endgenerate

   logic [S1_W-1:0] s1_in, s1_out;
   logic            s1_valid, s2_ready;

   assign s1_in = {mag[0], mag[1], mode, in_en};

   grad_pipe_reg #(.W(S1_W)) u_s1 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (s1_in),
      .out_valid (s1_valid),
      .out_ready (s2_ready),
      .out_data  (s1_out)
   );

   // ---------------- stage 2: combine ----------------
   logic [IN_W-1:0] a1, b1;
   logic [1:0]      m1;
   logic            en1;
   logic [IN_W:0]   mx, mn, comb;

   assign {a1, b1, m1, en1} = s1_out;
   assign mx = (a1 >= b1) ? {1'b0, a1} : {1'b0, b1};
   assign mn = (a1 >= b1) ? {1'b0, b1} : {1'b0, a1};

   always_comb begin
      comb = {1'b0, a1} + {1'b0, b1};
      case (grad_mode_t'(m1))
         GM_MAX:  comb = mx;
         GM_L2A:  comb = mx + (mn >> 1);
         default: comb = {1'b0, a1} + {1'b0, b1};
      endcase
   end

   logic [S2_W-1:0] s2_in, s2_out;
   logic            s2_valid, s3_ready;

   assign s2_in = {comb, en1};

   grad_pipe_reg #(.W(S2_W)) u_s2 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (s1_valid),
      .in_ready  (s2_ready),
      .in_data   (s2_in),
      .out_valid (s2_valid),
      .out_ready (s3_ready),
      .out_data  (s2_out)
   );

   // ---------------- stage 3: saturate and threshold ----------------
   logic [IN_W:0]    sum2;
   logic             en2;
   logic             over;
   logic [OUT_W-1:0] trunc;
   logic [OUT_W-1:0] g_val;
   logic             edge_val;

   assign {sum2, en2} = s2_out;

   generate
      if (IN_W + 1 > OUT_W) begin : g_sat
         assign over  = |sum2[IN_W:OUT_W];
         assign trunc = sum2[OUT_W-1:0];
      end else begin : g_nosat
         assign over  = 1'b0;
         assign trunc = OUT_W'(sum2);
      end
   endgenerate

   assign g_val    = !en2 ? '0 : (over ? '1 : trunc);
   assign edge_val = en2 && (g_val >= threshold);

   logic [S3_W-1:0] s3_in, s3_out;

   assign s3_in = {g_val, edge_val};

   grad_pipe_reg #(.W(S3_W)) u_s3 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (s2_valid),
      .in_ready  (s3_ready),
      .in_data   (s3_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (s3_out)
   );

   assign {g, is_edge} = s3_out;

   // ---------------- edge counter ----------------
   logic [CNT_W-1:0] count_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg <= '0;
      end else if (cnt_clear) begin
         count_reg <= '0;
      end else if (out_valid && out_ready && is_edge && (count_reg != '1)) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign edge_count = count_reg;

endmodule

// File: doc/grad_mag_pipe.md
GRAD_MAG_PIPE -- requirements
Module: grad_mag_pipe

Interface
REQ-001 Parameter IN_W, default 11, width of the signed two's-complement gx/gy inputs.
REQ-002 Parameter OUT_W, default 8, width of the unsigned saturated magnitude output.
REQ-003 Parameter CNT_W, default 16, width of the edge counter.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  input pixel gradient present.
REQ-007 in_ready  out  1  block can accept an input this cycle.
REQ-008 gx  in  IN_W  signed horizontal gradient.
REQ-009 gy  in  IN_W  signed vertical gradient.
REQ-010 in_en  in  1  per-pixel enable; 0 forces a zero result.
REQ-011 mode  in  2  per-pixel combine mode: 00 L1, 01 MAX, 10 L2-approx, 11 treated as L1.
REQ-012 threshold  in  OUT_W  quasi-static edge threshold, sampled at stage 3.
REQ-013 cnt_clear  in  1  synchronous clear of edge_count.
REQ-014 out_valid  out  1  result present.
REQ-015 out_ready  in  1  downstream accepts the result.
REQ-016 g  out  OUT_W  saturated magnitude.
REQ-017 edge  out  1  g >= threshold, forced 0 when the pixel's in_en = 0.
REQ-018 edge_count  out  CNT_W  saturating count of accepted outputs with edge = 1.

Function
REQ-019 Three-stage pipeline, each stage a valid/ready register slice; an input is accepted when in_valid && in_ready, and an output is transferred when out_valid && out_ready.
REQ-020 Latency is exactly 3 cycles from acceptance to out_valid when there is no backpressure; throughput is 1 pixel per cycle.
REQ-021 Each stage loads when its own valid is 0 or the next stage takes its data; in_ready = stage-1 load condition, fully registered per stage with no combinational in-to-out path except ready.
REQ-022 Stage 1: |gx| and |gy| as IN_W-bit unsigned values; the most negative input (-2^(IN_W-1)) yields 2^(IN_W-1) without overflow.
REQ-023 Stage 2: L1 = a+b, MAX = max(a,b), L2-approx = max(a,b) + (min(a,b)>>1), each computed at IN_W+1 bits with no loss.
REQ-024 Stage 3: g = all-ones when the stage-2 result > 2^OUT_W-1, else the result truncated to OUT_W bits; g = 0 when in_en = 0.
REQ-025 mode and in_en are captured at acceptance and travel with the pixel; changes mid-pipeline do not affect in-flight pixels.
REQ-026 With out_ready held low, up to 3 pixels are buffered, then in_ready = 0; no pixel is lost, duplicated or reordered.
REQ-027 edge_count increments by 1 on each output transfer with edge = 1; it holds at 2^CNT_W-1 once reached.
REQ-028 cnt_clear has priority over a simultaneous increment; edge_count = 0 on the following cycle.
REQ-029 g and edge hold stable while out_valid = 1 and out_ready = 0.

Reset
REQ-030 While rst is high: all stage valids = 0, out_valid = 0, g = 0, edge = 0, edge_count = 0, and in_ready = 1 after the first clock edge.
REQ-031 Reset mid-operation discards all in-flight pixels; no out_valid pulse occurs for them after rst deasserts.

Structure
REQ-032 Package grad_pkg holds the grad_mode_t enum (GM_L1, GM_MAX, GM_L2A, GM_RSVD) and the default IN_W/OUT_W/CNT_W constants.
REQ-033 Sub-module grad_pipe_reg, a parametrised-width valid/ready register slice, is instantiated three times.

Verification
REQ-034 L1, gx=3, gy=4, in_en=1, out_ready=1 -> g=7 exactly 3 cycles after acceptance; gx=-12, gy=13 -> g=25.
REQ-035 L1 with gx=200, gy=95 -> g=255; gx=-1024, gy=-1024 -> g=255; MAX with gx=-24, gy=106 -> g=106; L2-approx with gx=24, gy=106 -> g=118.
REQ-036 in_en=0, gx=71, gy=317, threshold=0 -> g=0, edge=0, and edge_count unchanged.
REQ-037 out_ready=0 while 5 pixels are offered back-to-back -> in_ready drops after 3 acceptances; after out_ready rises, all pixels emerge in order with correct values.
REQ-038 threshold=100, stream g values 99, 100, 255 -> edge = 0, 1, 1 and edge_count = 2; cnt_clear asserted with a simultaneous edge transfer -> edge_count = 0.
REQ-039 rst asserted with 2 pixels in flight -> out_valid = 0 and edge_count = 0 immediately; no stale output appears after rst deasserts.
